// File: rtl/id_stage_pipe.sv
// RV32 decode stage with register file, load-use interlock, flush and a registered ID/EX output.
// One cycle from accepted instruction to ex_valid; holds ID/EX while EX stalls and withholds id_ready on load-use.
package id_stage_pipe_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
endpackage

module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output alu_op_t          ex_alu_control,
  output logic [1:0]       ex_op_a_sel,
  output logic             ex_op_b_sel,
  output logic [1:0]       ex_wb_mux_sel,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_jalr,
  output logic [CNT_W-1:0] stall_count
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR   = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_IMM  = 7'b0010011, OP_REG  = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    alu_op_t         alu;
    logic [1:0]      op_a_sel;
    logic            op_b_sel;
    logic [1:0]      wb_sel;
    logic            reg_write, mem_write, branch, jump, jalr;
  } ex_t;

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  ex_t              ex_q, ex_d, dec;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [31:0] imm32;
  logic [6:0]       opcode;
  logic             rs1_used, rs2_used, hazard, out_free;

  function automatic logic in_range(input logic [4:0] r);
    return int'({27'd0, r}) < NUM_REGS;
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] r, input logic [XLEN-1:0] arr);
    logic [XLEN-1:0] v;
    v = '0;
    if (r != 5'd0 && in_range(r)) v = arr;
    if (WB_BYPASS && wb_we && wb_rd == r && r != 5'd0 && in_range(r)) v = wb_data;
    return v;
  endfunction

  function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ex_t kill(input ex_t e);
    ex_t k;
    k = e;
    k.reg_write = 1'b0; k.mem_write = 1'b0; k.branch = 1'b0; k.jump = 1'b0; k.jalr = 1'b0;
    return k;
  endfunction

  assign opcode = if_instr[6:0];

  // ControlUnit and ImmGen
  always_comb begin
    dec          = '0;
    imm32        = '0;
    dec.pc       = if_pc;
    dec.rd       = if_instr[11:7];
    dec.funct3   = if_instr[14:12];
    dec.rs1      = if_instr[19:15];
    dec.rs2      = if_instr[24:20];
    dec.alu      = ALU_ADD;
    case (opcode)
      OP_REG:   begin dec.reg_write = 1'b1; dec.alu = alu_dec(if_instr[14:12], if_instr[30]); end
      OP_IMM:   begin
        dec.reg_write = 1'b1; dec.op_b_sel = 1'b1;
        dec.alu = alu_dec(if_instr[14:12], if_instr[30] && if_instr[14:12] == 3'b101);
        imm32 = 32'($signed(if_instr[31:20]));
      end
      OP_LOAD:  begin
        dec.reg_write = 1'b1; dec.op_b_sel = 1'b1; dec.wb_sel = 2'b01;
        imm32 = 32'($signed(if_instr[31:20]));
      end
      OP_ST:    begin
        dec.mem_write = 1'b1; dec.op_b_sel = 1'b1;
        imm32 = 32'($signed({if_instr[31:25], if_instr[11:7]}));
      end
      OP_BR:    begin
        dec.branch = 1'b1;
        dec.alu = (if_instr[14:13] == 2'b00) ? ALU_SUB : (if_instr[13] ? ALU_SLTU : ALU_SLT);
        imm32 = 32'($signed({if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}));
      end
      OP_JAL:   begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.wb_sel = 2'b10;
        dec.op_a_sel = 2'b01; dec.op_b_sel = 1'b1;
        imm32 = 32'($signed({if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0}));
      end
      OP_JALR:  begin
        dec.reg_write = 1'b1; dec.jalr = 1'b1; dec.wb_sel = 2'b10; dec.op_b_sel = 1'b1;
        imm32 = 32'($signed(if_instr[31:20]));
      end
      OP_LUI:   begin
        dec.reg_write = 1'b1; dec.op_a_sel = 2'b10; dec.op_b_sel = 1'b1;
        imm32 = {if_instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.op_a_sel = 2'b01; dec.op_b_sel = 1'b1;
        imm32 = {if_instr[31:12], 12'd0};
      end
      default:  ;
    endcase
    dec.imm      = XLEN'(imm32);
    dec.rs1_data = rf_read(dec.rs1, regs_q[dec.rs1[AW-1:0]]);
    dec.rs2_data = rf_read(dec.rs2, regs_q[dec.rs2[AW-1:0]]);
  end

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG || opcode == OP_ST || opcode == OP_BR);
  assign hazard   = if_valid && ex_valid_q && ex_q.wb_sel == 2'b01 && ex_q.rd != 5'd0 &&
                    ((ex_q.rd == dec.rs1 && rs1_used) || (ex_q.rd == dec.rs2 && rs2_used));
  assign out_free = !ex_valid_q || ex_ready;
  assign id_ready = flush || (out_free && !hazard);

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_d       = kill(ex_q);
    end else if (hazard && out_free) begin
      ex_valid_d = 1'b0;
      ex_d       = kill(ex_q);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (if_valid && id_ready) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
    end else if (out_free) begin
      // out_free here implies no incoming instruction: drain to an empty slot
      ex_valid_d = 1'b0;
      ex_d       = kill(ex_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
      if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) regs_q[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_q.pc;
  assign ex_rs1_data    = ex_q.rs1_data;
  assign ex_rs2_data    = ex_q.rs2_data;
  assign ex_imm         = ex_q.imm;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_rd          = ex_q.rd;
  assign ex_funct3      = ex_q.funct3;
  assign ex_alu_control = ex_q.alu;
  assign ex_op_a_sel    = ex_q.op_a_sel;
  assign ex_op_b_sel    = ex_q.op_b_sel;
  assign ex_wb_mux_sel  = ex_q.wb_sel;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_jalr        = ex_q.jalr;
  assign stall_count    = cnt_q;
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised next-generation decode stage. It contains the architectural register file, ControlUnit, ImmGen and its own registered ID/EX output with valid/ready handshakes. It also includes load-use interlock, flush, WB-to-ID write-through bypass and a saturating stall counter. It sits between the IF/ID register and EX, and replaces the external ID/EX register.

Parameters:
XLEN, 32, datapath and register width
NUM_REGS, 32, architectural registers; power of two, 2..32; x0 hardwired zero
WB_BYPASS, 1, 1 = same-cycle WB-to-read write-through; 0 = read array only
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_valid  in  1  instruction/pc valid from IF
if_instr  in  32  fetched instruction
if_pc  in  XLEN  its PC
id_ready  out  1  ID accepts if_instr this cycle
flush  in  1  kill ID and ID/EX contents (branch/jump redirect)
wb_we  in  1  register write enable from WB
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB data
ex_valid  out  1  ID/EX holds a live instruction
ex_ready  in  1  EX accepts ID/EX contents
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
ex_funct3  out  3  registered funct3
ex_alu_control  out  alu_op_t  registered ALU op
ex_op_a_sel  out  2  registered
ex_op_b_sel  out  1  registered
ex_wb_mux_sel  out  2  registered; 2'b01 = load (memory result)
ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr  out  1 each  registered enables
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0, async): all ex_* outputs = 0, ex_valid = 0, all registers = 0, stall_count = 0.
- Decode is combinational from if_instr. Fields and immediate come from ControlUnit and ImmGen unchanged.
- Register file:
  - Write on clk when wb_we && wb_rd != 0 && wb_rd < NUM_REGS.
  - Reads of index 0 or index >= NUM_REGS return 0.
  - WB_BYPASS=1: a read with rs == wb_rd != 0 and wb_we=1 returns wb_data in the same cycle.
- Source usage:
  - rs1 is used unless the opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - rs2 is used only for OP (0110011), STORE (0100011) and BRANCH (1100011).
- Load-use hazard: hazard = if_valid && ex_valid && ex_wb_mux_sel == 2'b01 && ex_rd != 0 && (ex_rd == rs1 && rs1 used || ex_rd == rs2 && rs2 used).
- Readiness: out_free = !ex_valid || ex_ready; id_ready = flush || (out_free && !hazard).
- Per clock, in priority order:
  1. flush: ex_valid <= 0 and all ex enables <= 0. The IF instruction is consumed and dropped.
  2. hazard && out_free: insert bubble. ex_valid <= 0, enables <= 0, stall_count += 1 (saturating at all-ones).
  3. if_valid && id_ready: capture decoded instruction, ex_valid <= 1.
  4. out_free && !if_valid: ex_valid <= 0, enables <= 0.
  5. Otherwise (ex_valid && !ex_ready): hold all ex_* stable.
- hazard with !out_free: hold; stall_count does not increment.
- Bubble/empty: ex_reg_write, ex_mem_write, ex_branch, ex_jump and ex_jalr are 0. Data fields hold their last values.
- Latency: 1 cycle from accepted if_instr to ex_valid. Full throughput is 1 instruction/cycle when ex_ready=1 and there is no hazard.
- WB write and ID read of the same register in the same cycle: bypass value is captured into ex_rs*_data when WB_BYPASS=1; the old value when 0.
- Reset deasserted mid-stream: the pipeline restarts empty. No instruction is captured until after the first clk edge.

Test Plan:
- Reset, then stream addi x1,x0,5 / addi x2,x1,3 with ex_ready=1 -> ex_valid each cycle; ex_imm=5 then 3; ex_rs1=1 on 2nd; stall_count=0.
- lw x5,0(x1) followed by add x6,x5,x2 -> one bubble (ex_valid=0, ex_reg_write=0); id_ready=0 for 1 cycle; add issues next cycle; stall_count=1.
- lw x0,0(x1) then add x6,x0,x2 -> no stall.
- lui x5 after lw x5 -> no stall (rs1 unused).
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, id_ready=0; resumes with no loss or duplication.
- wb_we=1, wb_rd=7, wb_data=0xDEADBEEF in the same cycle ID decodes add x8,x7,x7 -> ex_rs1_data = ex_rs2_data = 0xDEADBEEF (WB_BYPASS=1); old value when WB_BYPASS=0.
- flush asserted with a valid ID/EX entry and if_valid=1 -> next cycle ex_valid=0 with all enables 0; the fetched instruction never appears at EX.
- Force 2^CNT_W+2 stalls with CNT_W=4 -> stall_count saturates at 15.
- Assert rst low mid-stream -> outputs zero immediately, without waiting for a clock edge.
